// File: rtl/filter_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_arb_pkg
// Brief    : Shared types for filter_arbiter (FSM states, in-flight tag, IDW).
// Revision : 1.0 - initial release
// ============================================================================
package filter_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Tag id field sized for the largest supported requester count (16).
  localparam int TAG_IDW = 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/filter_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : filter_arb_rr
// Brief    : N-way round-robin picker; first request at or after ptr wins.
// Revision : 1.0 - initial release
// ============================================================================
module filter_arb_rr #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [N-1:0]   rot;
  logic [IDW:0]   sum;

  assign rot = N'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDW+1)'(k);
      end
    end
    if (sum >= (IDW+1)'(N)) begin
      sum = sum - (IDW+1)'(N);
    end
    idx   = sum[IDW-1:0];
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/filter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : filter_arbiter
// Brief    : Round-robin sharing of one fixed-latency filter among N requesters,
//            with a tag pipeline routing results back. Optional feature macro:
//            FILTER_ARB_PARITY_CHECK_EN (drop bad-parity samples, pulse par_err).
// Revision : 1.0 - initial release
// ============================================================================
module filter_arbiter
  import filter_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_data,
  input  logic [N-1:0]   req_parity,
  output logic [W-1:0]   f_x_data,
  output logic           f_x_valid,
  output logic           f_x_parity,
  input  logic [W-1:0]   f_y_data,
  input  logic           f_y_valid,
  input  logic           f_y_parity,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_parity,
  output logic           idle,
  output logic           tag_err
`ifdef FILTER_ARB_PARITY_CHECK_EN
  ,
  output logic [N-1:0]   par_err
`endif
);

  localparam int IDW = calc_idw(N);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   grant;
  logic [IDW-1:0] gidx;
  logic           gany;
  logic           fire;
  logic           par_ok;
  logic           issue;
  logic [W-1:0]   sel_data;
  logic           sel_par;
  logic           busy;
  tag_t           f_x_tag;
  tag_t           tag_pipe [LATENCY];
  tag_t           tail;

  filter_arb_rr #(.N(N), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign req_ready = (state == ST_RUN && gany) ? grant : '0;
  assign fire      = |req_ready;
  assign sel_data  = req_data[gidx*W +: W];
  assign sel_par   = req_parity[gidx];
`ifdef FILTER_ARB_PARITY_CHECK_EN
  assign par_ok    = ((^sel_data) == sel_par);
`else
  assign par_ok    = 1'b1;
`endif
  assign issue     = fire & par_ok;

  // Tail lines up with the filter output LATENCY cycles after f_x_valid.
  assign tail       = tag_pipe[LATENCY-1];
  assign rsp_valid  = (f_y_valid && tail.valid) ? (N'(1) << tail.id) : '0;
  assign rsp_data   = f_y_data;
  assign rsp_parity = f_y_parity;
  assign idle       = (state == ST_IDLE);

  // The tail is being consumed this cycle, so it does not keep DRAIN alive.
  always_comb begin
    busy = f_x_valid;
    for (int k = 0; k < LATENCY - 1; k++) begin
      busy = busy | tag_pipe[k].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      f_x_valid  <= 1'b0;
      f_x_data   <= '0;
      f_x_parity <= 1'b0;
      f_x_tag    <= '0;
      tag_err    <= 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
`ifdef FILTER_ARB_PARITY_CHECK_EN
      par_err    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE:  if (enable) state <= ST_RUN;
        ST_RUN:   if (!enable) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable)     state <= ST_RUN;
          else if (!busy) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase

      if (fire) begin
        rr_ptr <= (gidx == IDW'(N-1)) ? '0 : gidx + IDW'(1);
      end

      f_x_valid     <= issue;
      f_x_data      <= issue ? sel_data : '0;
      f_x_parity    <= issue & sel_par;
      f_x_tag.valid <= issue;
      f_x_tag.id    <= issue ? TAG_IDW'(gidx) : '0;

      tag_pipe[0] <= f_x_tag;
      for (int k = 1; k < LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end

      if (f_y_valid != tail.valid) begin
        tag_err <= 1'b1;
      end
`ifdef FILTER_ARB_PARITY_CHECK_EN
      par_err <= (fire && !par_ok) ? req_ready : '0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_arbiter
// Brief    : Directed + random bench for filter_arbiter with a x4 filter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst, enable, inj;
  logic [N-1:0]   req_valid, req_ready, req_parity, rsp_valid;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   f_x_data, f_y_data, rsp_data;
  logic           f_x_valid, f_x_parity, f_y_valid, f_y_parity;
  logic           rsp_parity, idle, tag_err;
`ifdef FILTER_ARB_PARITY_CHECK_EN
  logic [N-1:0]   par_err;
`endif

  filter_arbiter #(.N(N), .W(W), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_parity(req_parity),
    .f_x_data(f_x_data), .f_x_valid(f_x_valid), .f_x_parity(f_x_parity),
    .f_y_data(f_y_data), .f_y_valid(f_y_valid), .f_y_parity(f_y_parity),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_parity(rsp_parity),
    .idle(idle), .tag_err(tag_err)
`ifdef FILTER_ARB_PARITY_CHECK_EN
    , .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  // Filter model: two-cycle latency, y = 4*x, parity passed through.
  logic         v1, v2, p1, p2;
  logic [W-1:0] d1, d2;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; p1 <= 1'b0; p2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v1 <= f_x_valid; d1 <= f_x_data << 2; p1 <= f_x_parity;
      v2 <= v1;        d2 <= d1;            p2 <= p1;
    end
  end
  assign f_y_valid  = v2 | inj;
  assign f_y_data   = d2;
  assign f_y_parity = p2;

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
    logic         par;
  } exp_t;

  exp_t q[$];
  int   cyc, ptr, n_cmp, n_err;
  bit   running;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict grant/response, compare, then advance the model at the edge.
  task automatic cycle();
    logic [N-1:0] er, ev;
    logic [W-1:0] d;
    exp_t         e;
    int           w;
    @(negedge clk);
    er = '0;
    ev = '0;
    w  = -1;
    if (running) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.id] = 1'b1;
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      check("rsp_parity", 32'(rsp_parity), 32'(e.par));
    end
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (w >= 0) begin
      ptr = (w + 1) % N;
      d   = req_data[w*W +: W];
`ifdef FILTER_ARB_PARITY_CHECK_EN
      if ((^d) == req_parity[w]) q.push_back('{cyc + 3, w, W'(d * 4), req_parity[w]});
`else
      q.push_back('{cyc + 3, w, W'(d * 4), req_parity[w]});
`endif
    end
    @(posedge clk);
    if (rst) begin
      running = 1'b0;
      ptr     = 0;
      q.delete();
    end else begin
      running = enable;
    end
    cyc++;
    #1;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
    req_parity[i]      = ^d;
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_f_x_valid", 32'(f_x_valid), 32'h0);
    check("rst_f_x_data", 32'(f_x_data), 32'h0);
    check("rst_f_x_parity", 32'(f_x_parity), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_tag_err", 32'(tag_err), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; inj = 1'b0;
    req_valid = '0; req_data = '0; req_parity = '0;
    cyc = 0; ptr = 0; n_cmp = 0; n_err = 0; running = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    check_reset_values();

    // Single request from requester 0, data 3 -> result 12 three cycles later.
    enable = 1'b1;
    cycle();
    req_valid = 4'b0001; set_lane(0, 16'd3);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // All requesters continuously valid, pointer restarted at 0.
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    req_valid = 4'b1111;
    repeat (5) begin
      for (int i = 0; i < N; i++) set_lane(i, W'($urandom));
      cycle();
    end
    req_valid = '0;
    repeat (4) cycle();

    // Enable dropped after a single accept from requester 2.
    req_valid = 4'b0100; set_lane(2, 16'd5);
    cycle();
    req_valid = '0; enable = 1'b0;
    cycle();
    check("drain_f_x_valid", 32'(f_x_valid), 32'h0);
    check("drain_idle_a", 32'(idle), 32'h0);
    cycle();
    check("drain_idle_b", 32'(idle), 32'h0);
    cycle();
    check("drain_idle_c", 32'(idle), 32'h1);

    // Reset with two samples in flight.
    enable = 1'b1;
    cycle();
    req_valid = 4'b0001; set_lane(0, W'($urandom));
    cycle();
    req_valid = 4'b0010; set_lane(1, W'($urandom));
    cycle();
    req_valid = '0; enable = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_values();
    repeat (4) cycle();
    check("post_rst_tag_err", 32'(tag_err), 32'h0);

    // Spurious filter result with nothing in flight.
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    check("spurious_tag_err", 32'(tag_err), 32'h1);
    repeat (2) cycle();
    check("sticky_tag_err", 32'(tag_err), 32'h1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("cleared_tag_err", 32'(tag_err), 32'h0);

`ifdef FILTER_ARB_PARITY_CHECK_EN
    // Bad parity from requester 1: accepted, not issued.
    enable = 1'b1;
    cycle();
    req_valid = 4'b0010; req_data[1*W +: W] = 16'd1; req_parity[1] = 1'b0;
    cycle();
    req_valid = '0;
    check("par_err_pulse", 32'(par_err), 32'h2);
    check("par_f_x_valid", 32'(f_x_valid), 32'h0);
    cycle();
    check("par_err_clear", 32'(par_err), 32'h0);
    repeat (3) cycle();
    enable = 1'b0;
    repeat (4) cycle();
`endif

    // Randomised traffic with occasional enable drops.
    repeat (400) begin
      enable    = ($urandom_range(0, 15) != 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_lane(i, W'($urandom));
      cycle();
    end
    enable = 1'b0; req_valid = '0;
    repeat (6) cycle();
    check("final_tag_err", 32'(tag_err), 32'h0);
    check("final_idle", 32'(idle), 32'h1);
    check("final_outstanding", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
